// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES chunks, one prefix-carry chunk per stage.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
    end

    // Returns {carry out, carry into MSB, sum} of one chunk.
    typedef logic [CW+1:0] res_t;

    function automatic res_t chunk_add(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                       input logic c);
        logic [CW-1:0] g, p, gp, pp;
        logic [CW:0]   cy;
        int unsigned   i;
        g  = x & y;
        p  = x ^ y;
        gp = g;
        pp = p;
        // Kogge-Stone span doubling; walking high-to-low keeps gp[i-d] at its previous level.
        for (int unsigned d = 1; d < CW; d = d * 2) begin
            for (int unsigned j = 0; j < CW - d; j++) begin
                i     = CW - 1 - j;
                gp[i] = gp[i] | (pp[i] & gp[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        cy[0] = c;
        for (int unsigned k = 0; k < CW; k++) begin
            cy[k+1] = gp[k] | (pp[k] & c);
        end
        return {cy[CW], cy[CW-1], p ^ cy[CW-1:0]};
    endfunction

    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic              c_q  [STAGES];
    logic [STAGES-1:0] vld;

    logic [WIDTH-1:0]  op_a [STAGES];
    logic [WIDTH-1:0]  op_b [STAGES];
    logic              op_c [STAGES];
    res_t              res  [STAGES];
    logic [STAGES-1:0] src_v;
    logic              stall;

    assign stall = vld[STAGES-1] & ~out_ready;

    if (STAGES == 1) begin : g_src_one
        assign src_v = in_valid;
    end else begin : g_src_many
        assign src_v = {vld[STAGES-2:0], in_valid};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign op_a[k] = a;
            assign op_b[k] = sub ? ~b : b;
            assign op_c[k] = sub ^ cin;
        end else begin : g_next
            assign op_a[k] = a_q[k-1];
            assign op_b[k] = b_q[k-1];
            assign op_c[k] = c_q[k-1];
        end
        assign res[k] = chunk_add(op_a[k][k*CW +: CW], op_b[k][k*CW +: CW], op_c[k]);
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_q;
`endif

    // a_q carries the finished sum chunks in its low bits and the pending operand A chunks above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
`ifdef PIPELINED_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (!stall) begin
            vld <= src_v;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (src_v[k]) begin
                    a_q[k]            <= op_a[k];
                    a_q[k][k*CW +: CW] <= res[k][CW-1:0];
                    b_q[k]            <= op_b[k];
                    c_q[k]            <= res[k][CW+1];
                end
            end
`ifdef PIPELINED_ADDER_OVF_EN
            if (src_v[STAGES-1]) begin
                ovf_q <= res[STAGES-1][CW+1] ^ res[STAGES-1][CW];
            end
`endif
        end
    end

    assign in_ready  = ~stall;
    assign out_valid = vld[STAGES-1];
    assign s         = a_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign busy      = |vld;
`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4) against a queue-based arithmetic model.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cout;
    logic         busy;
`ifdef PIPELINED_ADDER_OVF_EN
    logic         ovf;
`endif

    pipelined_adder #(.WIDTH(W), .STAGES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .busy(busy)
`ifdef PIPELINED_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t        q[$];
    int unsigned cmp_n = 0;
    int unsigned mis_n = 0;
    int unsigned sent  = 0;
    int unsigned recv  = 0;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t         e;
        logic [W-1:0] ye;
        logic [W:0]   t;
        ye  = sb ? ~y : y;
        t   = {1'b0, x} + {1'b0, ye} + (W+1)'(sb ? !ci : ci);
        e.s = t[W-1:0];
        e.c = t[W];
        e.o = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        cmp_n++;
        assert (got === want)
        else begin
            mis_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: sample handshakes mid-cycle, score any output beat, then advance.
    task automatic step(output bit acc);
        exp_t e;
        bit   xo, xi;
        #1;
        xo = out_valid & out_ready;
        xi = in_valid & in_ready;
        if (xo) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check("s", 64'(s), 64'(e.s));
                check("cout", 64'(cout), 64'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
                check("ovf", 64'(ovf), 64'(e.o));
`endif
                recv++;
            end
        end
        if (xi) begin
            q.push_back(model(a, b, cin, sub));
            sent++;
        end
        acc = xi;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb);
        bit acc;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(acc);
        if (!acc) check("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) step(acc);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit acc;
        int n;
        int unsigned r0;

        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full carry ripple through every chunk boundary; latency measurement
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("busy_in_flight", 64'(busy), 64'd1);
        n = 1;
        while (!out_valid && n < 20) begin
            step(acc);
            n++;
        end
        check("latency", 64'(n), 64'(N));
        check("direct_s", 64'(s), 64'h0);
        check("direct_cout", 64'(cout), 64'd1);
        drain();

        // Subtract with and without borrow
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'd7, 32'd5, 1'b0, 1'b1);
        drain();

        // Back-to-back stream, full throughput
        r0 = recv;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = W'(i); b = 32'h1000_0000 * W'(i); cin = i[0]; sub = 1'b0; in_valid = 1'b1;
            check("stream_in_ready", 64'(in_ready), 64'd1);
            step(acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) step(acc);
        check("stream_consecutive", 64'(recv - r0), 64'd16);
        drain();

        // Backpressure: 5 stalled cycles once results appear
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        check("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
            check("bp_s_held", 64'(s), 64'(q[0].s));
        end
        out_ready = 1'b1;
        send(a, b, cin, sub);
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain();

        // Asynchronous reset with three beats in flight
        for (int i = 0; i < 3; i++) send($urandom | 32'h1, 32'h0F0F_0F0F, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_s", 64'(s), 64'd0);
        check("arst_cout", 64'(cout), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        sent = recv;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) step(acc);
        check("post_rst_busy", 64'(busy), 64'd0);

`ifdef PIPELINED_ADDER_OVF_EN
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        drain();
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
            step(acc);
        end
        drain();

        check("total_beats", 64'(recv), 64'(sent));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
        $finish;
    end

endmodule
